// File: rtl/imm_decode_queue.sv
// -----------------------------------------------------------------------------
// imm_decode_queue
//   Two-entry instruction queue that classifies each MIPS instruction word as it
//   is pushed. The immediate extension mode, the has-immediate flag, the illegal
//   flag and the extended immediate are stored with the raw word, so the head
//   entry presents a fully decoded immediate with no decode logic on the
//   output path.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   instruction offered
//   in_instr     in   [31:0] raw instruction word
//   in_ready     out  queue can accept this cycle (count < 2)
//   out_valid    out  head entry valid (count > 0)
//   out_ready    in   consumer takes the head this cycle
//   out_instr    out  [31:0] head instruction word
//   out_imm      out  [31:0] extended immediate of the head
//   out_mode     out  [1:0] 0 sign 15:0, 1 zero 15:0, 2 zero 25:0, 3 zero 10:6
//   out_has_imm  out  head uses an immediate
//   out_illegal  out  head opcode/funct unrecognised
//   flush        in   discard all queued entries
//   illegal_cnt  out  [7:0] saturating count of illegal instructions accepted
// -----------------------------------------------------------------------------
module imm_decode_queue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_imm,
    output logic [1:0]  out_mode,
    output logic        out_has_imm,
    output logic        out_illegal,
    input  logic        flush,
    output logic [7:0]  illegal_cnt
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [1:0]  mode;
        logic        has_imm;
        logic        illegal;
    } entry_t;

    // Decode one instruction word into a queue entry.
    function automatic entry_t classify(input logic [31:0] i);
        entry_t e;
        e.instr   = i;
        e.imm     = 32'd0;
        e.mode    = 2'd0;
        e.has_imm = 1'b0;
        e.illegal = 1'b0;
        case (i[31:26])
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: begin
                e.mode    = 2'd0;
                e.has_imm = 1'b1;
                e.imm     = {{16{i[15]}}, i[15:0]};
            end
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                e.mode    = 2'd1;
                e.has_imm = 1'b1;
                e.imm     = {16'd0, i[15:0]};
            end
            6'h02, 6'h03: begin
                e.mode    = 2'd2;
                e.has_imm = 1'b1;
                e.imm     = {6'd0, i[25:0]};
            end
            6'h00: begin
                // Only the constant-shift R-types carry an immediate (shamt);
                // every other funct is a legal register-register op.
                if ((i[5:0] == 6'h00) || (i[5:0] == 6'h02) || (i[5:0] == 6'h03)) begin
                    e.mode    = 2'd3;
                    e.has_imm = 1'b1;
                    e.imm     = {27'd0, i[10:6]};
                end else begin
                    e.mode    = 2'd0;
                    e.has_imm = 1'b0;
                end
            end
            default: begin
                e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

    entry_t      entry_q [0:1];
    entry_t      entry_d [0:1];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [7:0]  illegal_cnt_q, illegal_cnt_d;

    logic        push_s;
    logic        pop_s;
    entry_t      new_entry_s;
    entry_t      head_s;

    // Handshake status comes from the registered count only.
    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push_s    = in_valid && in_ready && !flush;
    assign pop_s     = out_valid && out_ready && !flush;

    assign new_entry_s = classify(in_instr);
    assign head_s      = entry_q[rd_ptr_q];

    // Empty queue presents all-zero entry fields.
    assign out_instr   = out_valid ? head_s.instr   : 32'd0;
    assign out_imm     = out_valid ? head_s.imm     : 32'd0;
    assign out_mode    = out_valid ? head_s.mode    : 2'd0;
    assign out_has_imm = out_valid ? head_s.has_imm : 1'b0;
    assign out_illegal = out_valid ? head_s.illegal : 1'b0;
    assign illegal_cnt = illegal_cnt_q;

    // Next-state for pointers, count, storage and the illegal counter.
    always_comb begin
        entry_d[0]    = entry_q[0];
        entry_d[1]    = entry_q[1];
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        illegal_cnt_d = illegal_cnt_q;

        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_s) begin
                entry_d[wr_ptr_q] = new_entry_s;
                wr_ptr_d          = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        // Counter ignores flush; push_s is already masked by flush.
        if (push_s && new_entry_s.illegal && (illegal_cnt_q != 8'hFF)) begin
            illegal_cnt_d = illegal_cnt_q + 8'd1;
        end else begin
            illegal_cnt_d = illegal_cnt_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q[0]    <= '0;
            entry_q[1]    <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            illegal_cnt_q <= 8'd0;
        end else begin
            entry_q[0]    <= entry_d[0];
            entry_q[1]    <= entry_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

endmodule

// File: tb/tb_imm_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_imm_decode_queue
//   Self-checking bench for imm_decode_queue: directed scenarios followed by
//   randomized traffic, all compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_imm_decode_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_imm;
    logic [1:0]  out_mode;
    logic        out_has_imm;
    logic        out_illegal;
    logic        flush;
    logic [7:0]  illegal_cnt;

    imm_decode_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_imm     (out_imm),
        .out_mode    (out_mode),
        .out_has_imm (out_has_imm),
        .out_illegal (out_illegal),
        .flush       (flush),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        int          mode;
        bit          has_imm;
        bit          illegal;
    } ref_entry_t;

    ref_entry_t model_q[$];
    int         model_cnt;
    int         checks;
    int         failures;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode written from the opcode tables.
    function automatic ref_entry_t ref_decode(input logic [31:0] w);
        ref_entry_t e;
        int op;
        int fn;
        op = int'(w >> 26);
        fn = int'(w & 32'h3F);
        e.instr = w; e.imm = 32'd0; e.mode = 0; e.has_imm = 1'b0; e.illegal = 1'b0;
        if (op == 1 || (op >= 4 && op <= 11) ||
            op inside {32, 33, 35, 36, 37, 40, 41, 43}) begin
            e.has_imm = 1'b1;
            e.imm = (w & 32'h0000FFFF);
            if (e.imm >= 32'h8000) e.imm = e.imm + 32'hFFFF0000;
        end else if (op >= 12 && op <= 15) begin
            e.mode = 1; e.has_imm = 1'b1; e.imm = w & 32'h0000FFFF;
        end else if (op == 2 || op == 3) begin
            e.mode = 2; e.has_imm = 1'b1; e.imm = w % 32'h04000000;
        end else if (op == 0) begin
            if (fn == 0 || fn == 2 || fn == 3) begin
                e.mode = 3; e.has_imm = 1'b1; e.imm = (w / 64) % 32;
            end
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    task automatic compare_all();
        check_eq("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
        check_eq("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        check_eq("illegal_cnt", 32'(illegal_cnt), 32'(model_cnt));
        if (model_q.size() > 0) begin
            check_eq("out_instr", out_instr, model_q[0].instr);
            check_eq("out_imm", out_imm, model_q[0].imm);
            check_eq("out_mode", 32'(out_mode), 32'(model_q[0].mode));
            check_eq("out_has_imm", 32'(out_has_imm), 32'(model_q[0].has_imm));
            check_eq("out_illegal", 32'(out_illegal), 32'(model_q[0].illegal));
        end else begin
            check_eq("empty_fields", {out_instr ^ out_imm, 30'd0} | 32'({out_mode, out_has_imm, out_illegal}), 32'd0);
            check_eq("empty_instr", out_instr, 32'd0);
        end
    endtask

    // One cycle: check current outputs, drive inputs, advance the model and clock.
    task automatic step(input bit iv, input logic [31:0] w, input bit ordy, input bit fl);
        bit push;
        bit pop;
        ref_entry_t e;
        compare_all();
        in_valid = iv; in_instr = w; out_ready = ordy; flush = fl;
        push = iv && (model_q.size() < 2) && !fl;
        pop  = (model_q.size() > 0) && ordy && !fl;
        e = ref_decode(w);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back(e);
        end
        if (push && e.illegal && model_cnt < 255) model_cnt++;
        @(negedge clk);
    endtask

    logic [31:0] rw;
    int          saved_cnt;

    initial begin
        checks = 0; failures = 0; model_cnt = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // addi into empty queue appears next cycle
        step(1'b1, 32'h2008FFFC, 1'b1, 1'b0);
        check_eq("addi_valid", 32'(out_valid), 32'd1);
        check_eq("addi_imm", out_imm, 32'hFFFFFFFC);
        check_eq("addi_mode", 32'(out_mode), 32'd0);
        check_eq("addi_has", 32'(out_has_imm), 32'd1);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // ori then jal held, queue fills, third offer refused
        step(1'b1, 32'h3508F000, 1'b0, 1'b0);
        step(1'b1, 32'h0C100040, 1'b0, 1'b0);
        check_eq("full_ready", 32'(in_ready), 32'd0);
        check_eq("ori_imm", out_imm, 32'h0000F000);
        check_eq("ori_mode", 32'(out_mode), 32'd1);
        step(1'b1, 32'h2008FFFC, 1'b1, 1'b0);
        check_eq("jal_imm", out_imm, 32'h00100040);
        check_eq("jal_mode", 32'(out_mode), 32'd2);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("drained", 32'(out_valid), 32'd0);

        // sll shamt and add
        step(1'b1, 32'h00084140, 1'b1, 1'b0);
        check_eq("sll_mode", 32'(out_mode), 32'd3);
        check_eq("sll_imm", out_imm, 32'h00000005);
        step(1'b1, 32'h01095020, 1'b1, 1'b0);
        check_eq("add_has", 32'(out_has_imm), 32'd0);
        check_eq("add_imm", out_imm, 32'd0);
        check_eq("add_ill", 32'(out_illegal), 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // flush a full queue while offering an illegal word
        step(1'b1, 32'hFC000000, 1'b0, 1'b0);
        step(1'b1, 32'h2008FFFC, 1'b0, 1'b0);
        saved_cnt = int'(illegal_cnt);
        check_eq("pre_flush_cnt", 32'(saved_cnt), 32'd1);
        step(1'b1, 32'hFC000000, 1'b0, 1'b1);
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        check_eq("flush_ready", 32'(in_ready), 32'd1);
        check_eq("flush_cnt", 32'(illegal_cnt), 32'(saved_cnt));

        // 300 illegal pushes, counter saturates
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 32'hFC000000, 1'b1, 1'b0);
            check_eq("ill_flag", 32'(out_illegal), 32'd1);
        end
        check_eq("ill_sat", 32'(illegal_cnt), 32'd255);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // asynchronous reset with two entries held
        step(1'b1, 32'h3508F000, 1'b0, 1'b0);
        step(1'b1, 32'h0C100040, 1'b0, 1'b0);
        check_eq("held_two", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_eq("rst_cnt", 32'(illegal_cnt), 32'd0);
        check_eq("rst_instr", out_instr, 32'd0);
        model_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h2008FFFC, 1'b0, 1'b0);
        check_eq("post_rst_valid", 32'(out_valid), 32'd1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rw = $urandom;
            if ($urandom_range(3) == 0) begin
                rw[31:26] = 6'd0;
                case ($urandom_range(2))
                    0:       rw[5:0] = 6'h00;
                    1:       rw[5:0] = 6'h02;
                    default: rw[5:0] = 6'h03;
                endcase
            end
            step(($urandom_range(3) != 0), rw, ($urandom_range(2) != 0), ($urandom_range(19) == 0));
        end
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
